// File: rtl/soc_bus_pkg.sv
// rtl/soc_bus_pkg.sv - shared defaults and types for the SoC data-bus router
package soc_bus_pkg;

    localparam int DEF_NUM_SLAVES = 8;
    localparam int TGT_W          = $clog2(DEF_NUM_SLAVES + 1);

    typedef logic [TGT_W-1:0] tgt_idx_t;

    // The error responder occupies the index one past the last real slave.
    localparam tgt_idx_t ERR_IDX = tgt_idx_t'(DEF_NUM_SLAVES);

    localparam logic [DEF_NUM_SLAVES-1:0][31:0] DEF_SLAVE_BASE = {
        32'h0101_0000, 32'h0100_3000, 32'h0100_2000, 32'h0100_1000,
        32'h0100_0000, 32'h0010_0000, 32'h0001_0000, 32'h0000_0000
    };

    localparam logic [DEF_NUM_SLAVES-1:0][31:0] DEF_SLAVE_MASK = {
        32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000,
        32'hFFFF_F000, 32'hFFFF_C000, 32'hFFFF_C000, 32'hFFFF_F000
    };

    localparam logic [31:0] DEF_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/soc_route_fifo.sv
// rtl/soc_route_fifo.sv - synchronous FIFO of issued target indices
module soc_route_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a full FIFO may still accept.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/soc_bus_router.sv
// rtl/soc_bus_router.sv - 1-master/N-slave data-bus router with base/mask decode
module soc_bus_router
    import soc_bus_pkg::*;
#(
    parameter int NUM_SLAVES = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_OUTST  = 2,
    parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLAVE_BASE = DEF_SLAVE_BASE,
    parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLAVE_MASK = DEF_SLAVE_MASK,
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA = DEF_ERR_RDATA
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             m_req,
    output logic                             m_gnt,
    input  logic [ADDR_WIDTH-1:0]            m_addr,
    input  logic                             m_we,
    input  logic [DATA_WIDTH/8-1:0]          m_be,
    input  logic [DATA_WIDTH-1:0]            m_wdata,
    output logic                             m_rvalid,
    output logic [DATA_WIDTH-1:0]            m_rdata,
    output logic                             m_err,
    output logic [NUM_SLAVES-1:0]            s_req,
    input  logic [NUM_SLAVES-1:0]            s_gnt,
    output logic [ADDR_WIDTH-1:0]            s_addr,
    output logic                             s_we,
    output logic [DATA_WIDTH/8-1:0]          s_be,
    output logic [DATA_WIDTH-1:0]            s_wdata,
    input  logic [NUM_SLAVES-1:0]            s_rvalid,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
    output logic [15:0]                      err_count
);

    localparam int            TW      = $clog2(NUM_SLAVES + 1);
    localparam logic [TW-1:0] ERR_TGT = TW'(NUM_SLAVES);

    logic [TW-1:0]         tgt, head;
    logic                  fifo_full, fifo_empty;
    logic                  tgt_is_err, head_is_err;
    logic                  sel_gnt, issue_ok, rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic [NUM_SLAVES-1:0] exp_rvalid;
    logic                  stray_rvalid;
    logic                  err_pend_q, err_pend_d;
    logic [15:0]           err_count_q, err_count_d;

    assign s_addr  = m_addr;
    assign s_we    = m_we;
    assign s_be    = m_be;
    assign s_wdata = m_wdata;

    // Scan downwards so the lowest matching index is the one left standing.
    always_comb begin
        tgt = ERR_TGT;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((m_addr & SLAVE_MASK[i]) == SLAVE_BASE[i]) begin
                tgt = TW'(i);
            end
        end
    end

    assign tgt_is_err  = (tgt == ERR_TGT);
    assign head_is_err = (head == ERR_TGT);

    always_comb begin
        sel_gnt = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (tgt == TW'(i)) begin
                sel_gnt = s_gnt[i];
            end
        end
    end

    // All queued routes share one target, so the head doubles as last-issued.
    assign issue_ok = !rst && m_req && (!fifo_full || rsp_valid)
                    && (fifo_empty || (tgt == head));
    assign m_gnt    = issue_ok && (tgt_is_err || sel_gnt);

    always_comb begin
        s_req = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (issue_ok && (tgt == TW'(i))) begin
                s_req[i] = 1'b1;
            end
        end
    end

    always_comb begin
        rsp_valid  = 1'b0;
        rsp_data   = '0;
        exp_rvalid = '0;
        if (!rst && !fifo_empty) begin
            if (head_is_err) begin
                rsp_valid = err_pend_q;
                rsp_data  = ERR_RDATA;
            end else begin
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    if (head == TW'(i)) begin
                        exp_rvalid[i] = 1'b1;
                        rsp_valid     = s_rvalid[i];
                        rsp_data      = s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    assign m_rvalid = rsp_valid;
    assign m_rdata  = rsp_valid ? rsp_data : '0;
    assign m_err    = rsp_valid && head_is_err;

    soc_route_fifo #(
        .WIDTH (TW),
        .DEPTH (MAX_OUTST)
    ) u_route_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (m_gnt),
        .data_i  (tgt),
        .pop_i   (rsp_valid),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign err_pend_d = m_gnt && tgt_is_err;

    always_comb begin
        err_count_d = err_count_q;
        if (err_pend_q && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_pend_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_pend_q  <= err_pend_d;
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;

    assign stray_rvalid = |(s_rvalid & ~exp_rvalid);

    a_no_stray_rvalid: assert property (@(posedge clk) disable iff (rst) !stray_rvalid);

endmodule
